// File: rtl/range_match_pkg.sv
// Shared types and helpers for the pipelined range-match tree.
// RANGE_MATCH_TAG_EN adds a side-band tag field to the stage record.
package range_match_pkg;
   localparam int unsigned rm_data_width = 8;
   localparam int unsigned rm_levels     = 3;
`ifdef RANGE_MATCH_TAG_EN
   localparam int unsigned rm_tag_width  = 8;
`endif
   localparam int unsigned m             = (1 << rm_levels) - 1;

   typedef logic [rm_data_width-1:0] key_t;
   typedef logic [rm_levels-1:0]     prefix_t;
`ifdef RANGE_MATCH_TAG_EN
   typedef logic [rm_tag_width-1:0]  tag_t;
`endif

   typedef struct packed {
      logic    valid;
      key_t    key;
      prefix_t prefix;
`ifdef RANGE_MATCH_TAG_EN
      tag_t    tag;
`endif
   } stage_rec_t;

   // Boundary probed at depth k: midpoint of the subtree selected by prefix p.
   function automatic int unsigned node_idx(input int unsigned k, input int unsigned p,
                                            input int unsigned lv);
      return (((p << 1) | 1) << (lv - 1 - k)) - 1;
   endfunction
endpackage

// File: rtl/range_match_stage.sv
// One registered compare level of the range-match tree; appends one prefix bit per key.
module range_match_stage
   import range_match_pkg::*;
#(
   parameter int unsigned k = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       stall,
   input  key_t       bnd [m],
   input  stage_rec_t rec_in,
   output stage_rec_t rec_out
);
   prefix_t    idx;
   logic       ge;
   stage_rec_t rec_d;

   // Prefix bits above k are still zero here, so the full prefix value is the subtree id.
   always_comb begin
      idx          = prefix_t'(node_idx(k, 32'(rec_in.prefix), rm_levels));
      ge           = rec_in.key >= bnd[idx];
      rec_d        = rec_in;
      rec_d.prefix = prefix_t'({rec_in.prefix, ge});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rec_out <= '0;
      end else if (!stall) begin
         rec_out <= rec_d;
      end
   end
endmodule

// File: rtl/range_match_pipe.sv
// Pipelined range-match tree: one registered compare per level, in-band boundary rewrite.
// Define RANGE_MATCH_TAG_EN to carry a side-band tag alongside each key.
module range_match_pipe
   import range_match_pkg::*;
#(
   parameter int unsigned data_width = rm_data_width,
   parameter int unsigned levels     = rm_levels
`ifdef RANGE_MATCH_TAG_EN
   ,
   parameter int unsigned tag_width  = rm_tag_width
`endif
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [data_width-1:0] in_key,
`ifdef RANGE_MATCH_TAG_EN
   input  logic [tag_width-1:0]  in_tag,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [levels-1:0]     range_id,
`ifdef RANGE_MATCH_TAG_EN
   output logic [tag_width-1:0]  out_tag,
`endif
   input  logic                  cfg_we,
   input  logic [levels-1:0]     cfg_addr,
   input  logic [data_width-1:0] cfg_data,
   output logic                  cfg_ready
);
   key_t       bnd [m];
   stage_rec_t head;
   stage_rec_t chain [levels];
   logic       stall;
   logic       busy;

   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall & ~cfg_we;
   assign cfg_ready = ~busy;
   assign out_valid = chain[levels-1].valid;
   assign range_id  = chain[levels-1].prefix;
`ifdef RANGE_MATCH_TAG_EN
   assign out_tag   = chain[levels-1].tag;
`endif

   // Any key in flight, including the presented result, holds off table writes.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < int'(levels); i++) begin
         busy = busy | chain[i].valid;
      end
   end

   always_comb begin
      head       = '0;
      head.valid = in_valid & in_ready;
      head.key   = key_t'(in_key);
`ifdef RANGE_MATCH_TAG_EN
      head.tag   = in_tag;
`endif
   end

   // Boundary table; address m is acknowledged but dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(m); i++) begin
            bnd[i] <= '1;
         end
      end else if (cfg_we && cfg_ready && (32'(cfg_addr) < m)) begin
         bnd[cfg_addr] <= key_t'(cfg_data);
      end
   end

   for (genvar g = 0; g < int'(levels); g++) begin : g_stage
      if (g == 0) begin : g_first
         range_match_stage #(.k(0)) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .stall   (stall),
            .bnd     (bnd),
            .rec_in  (head),
            .rec_out (chain[0])
         );
      end else begin : g_rest
         range_match_stage #(.k(g)) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .stall   (stall),
            .bnd     (bnd),
            .rec_in  (chain[g-1]),
            .rec_out (chain[g])
         );
      end
   end
endmodule

// File: tb/tb_range_match_pipe.sv
// Scoreboard bench for range_match_pipe: expected ids come from counting boundaries <= key.
module tb_range_match_pipe;
   localparam int unsigned dw = 8;
   localparam int unsigned lv = 3;
   localparam int unsigned nb = (1 << lv) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid, in_ready, out_valid, out_ready, cfg_we, cfg_ready;
   logic [dw-1:0] in_key, cfg_data;
   logic [lv-1:0] range_id, cfg_addr;
   logic [7:0]    tag_v;
`ifdef RANGE_MATCH_TAG_EN
   logic [7:0]    in_tag, out_tag;
`endif

   typedef struct {
      logic [lv-1:0] id;
      logic [7:0]    tag;
      int            acc;
      int            stl;
   } exp_t;

   exp_t          sb [$];
   logic [dw-1:0] tbl [nb];
   int            total = 0;
   int            passed = 0;
   int            cyc = 0;
   int            stall_cnt = 0;
   bit            expect_ready = 1'b0;
   bit            rdone = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   range_match_pipe dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_key    (in_key),
`ifdef RANGE_MATCH_TAG_EN
      .in_tag    (in_tag),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .range_id  (range_id),
`ifdef RANGE_MATCH_TAG_EN
      .out_tag   (out_tag),
`endif
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready)
   );

   function automatic void check(input bit ok, input string name, input int act, input int exp);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endfunction

   // Reference: the range index is simply how many boundaries are <= key.
   function automatic logic [lv-1:0] model_id(input logic [dw-1:0] key);
      int c = 0;
      for (int i = 0; i < int'(nb); i++) if (tbl[i] <= key) c++;
      return lv'(c);
   endfunction

   function automatic void reset_model();
      for (int i = 0; i < int'(nb); i++) tbl[i] = '1;
      sb.delete();
   endfunction

   function automatic logic [dw-1:0] pick_key();
      logic [dw-1:0] b;
      if ($urandom_range(0, 1) == 0) return dw'($urandom);
      b = tbl[$urandom_range(0, nb - 1)];
      return dw'(b + dw'($urandom_range(0, 2)) - dw'(1));
   endfunction

   // Monitor: pops and compares on every output handshake, checks hold while stalled.
   initial begin
      exp_t          e;
      bit            held = 1'b0;
      bit            ok;
      logic [lv-1:0] held_id = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check(out_valid == 1'b1, "hold_valid", int'(out_valid), 1);
               check(range_id == held_id, "hold_id", int'(range_id), int'(held_id));
            end
            held = 1'b0;
            if (out_valid && !out_ready) begin
               stall_cnt++;
               held    = 1'b1;
               held_id = range_id;
            end else if (out_valid) begin
               ok = sb.size() != 0;
               check(ok, "spurious_out", 1, 0);
               if (ok) begin
                  e = sb.pop_front();
                  check(range_id == e.id, "range_id", int'(range_id), int'(e.id));
`ifdef RANGE_MATCH_TAG_EN
                  check(out_tag == e.tag, "out_tag", int'(out_tag), int'(e.tag));
`endif
                  check((cyc - e.acc) == 3 + (stall_cnt - e.stl), "latency",
                        cyc - e.acc, 3 + (stall_cnt - e.stl));
               end
            end
         end
      end
   end

   // exp_id < 0 means take the expectation from the reference model.
   task automatic send(input logic [dw-1:0] key, input int exp_id);
      bit   done = 1'b0;
      int   n = 0;
      exp_t e;
      in_valid = 1'b1;
      in_key   = key;
      tag_v    = 8'($urandom);
`ifdef RANGE_MATCH_TAG_EN
      in_tag   = tag_v;
`endif
      while (!done && n < 200) begin
         @(negedge clk);
         if (expect_ready) check(in_ready == 1'b1, "in_ready_stream", int'(in_ready), 1);
         if (in_ready) begin
            e.id  = (exp_id < 0) ? model_id(key) : lv'(exp_id);
            e.tag = tag_v;
            e.acc = cyc;
            e.stl = stall_cnt;
            sb.push_back(e);
            done = 1'b1;
         end
         n++;
         @(posedge clk);
         #1;
      end
      check(done, "accept_timeout", n, 0);
      in_valid = 1'b0;
   endtask

   task automatic cfg_write(input logic [lv-1:0] a, input logic [dw-1:0] d);
      bit done = 1'b0;
      int n = 0;
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      while (!done && n < 300) begin
         @(negedge clk);
         check(in_ready == 1'b0, "in_ready_cfg", int'(in_ready), 0);
         if (cfg_ready) begin
            check(sb.size() == 0, "drained_before_write", sb.size(), 0);
            if (int'(a) < int'(nb)) tbl[a] = d;
            done = 1'b1;
         end
         n++;
         @(posedge clk);
         #1;
      end
      check(done, "cfg_timeout", n, 0);
      cfg_we = 1'b0;
   endtask

   task automatic new_table();
      int v = int'($urandom_range(0, 30));
      for (int i = 0; i < int'(nb); i++) begin
         cfg_write(lv'(i), dw'(v));
         v += int'($urandom_range(0, 40));
         if (v > 255) v = 255;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_key    = '0;
      out_ready = 1'b1;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      tag_v     = '0;
`ifdef RANGE_MATCH_TAG_EN
      in_tag    = '0;
`endif
      reset_model();
      repeat (3) @(posedge clk);
      #1;
      check(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
      check(range_id == '0, "reset_range_id", int'(range_id), 0);
      check(cfg_ready == 1'b1, "reset_cfg_ready", int'(cfg_ready), 1);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // All-ones table after reset
      send(8'd254, 0);
      send(8'd255, 7);

      for (int i = 0; i < int'(nb); i++) cfg_write(lv'(i), dw'(10 * (i + 1)));
      send(8'd9, 0);
      send(8'd10, 1);
      send(8'd35, 3);
      send(8'd70, 7);
      send(8'd255, 7);

      expect_ready = 1'b1;
      for (int i = 0; i < 20; i++) send(pick_key(), -1);
      expect_ready = 1'b0;

      // Five-cycle downstream stall in the middle of a stream
      fork
         begin
            for (int i = 0; i < 15; i++) send(pick_key(), -1);
         end
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!out_valid && n < 50);
            @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check(in_ready == 1'b0, "in_ready_stall", int'(in_ready), 0);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join

      // Write raised with three keys in flight, then the new boundary is used
      send(8'd12, 1);
      send(8'd44, 4);
      send(8'd61, 6);
      cfg_write(3'd3, 8'd36);
      send(8'd37, 4);
      send(8'd35, 3);
      cfg_write(3'd7, 8'd0);
      send(8'd15, 1);
      send(8'd36, 4);

      // Random traffic, random back-pressure, periodic table rewrites
      fork
         begin
            for (int i = 0; i < 250; i++) begin
               if (i % 60 == 30) new_table();
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               send(pick_key(), -1);
            end
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check(sb.size() == 0, "drain", sb.size(), 0);
      #1;

      // Reset pulsed with keys in flight
      cfg_write(3'd0, 8'd5);
      send(8'd100, -1);
      send(8'd101, -1);
      send(8'd102, -1);
      #2 reset_n = 1'b0;
      #1;
      check(out_valid == 1'b0, "midreset_out_valid", int'(out_valid), 0);
      check(range_id == '0, "midreset_range_id", int'(range_id), 0);
      reset_model();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'd35, 0);
      send(8'd255, 7);

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check(sb.size() == 0, "final_drain", sb.size(), 0);
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/range_match_pipe.md
# range_match_pipe

Pipelined, parametrised range-match tree: classifies one `data_width`-bit packet-header field per cycle against a programmable, ascending-sorted table of `2**levels - 1` range boundaries and returns the index of the matching range. Each tree level is one registered min-max compare stage, which supersedes the purely combinational single-compare processing element. It sits between the header-field extractor and the per-field rule-bitmap lookup in the classification datapath. Valid/ready handshakes on both sides; boundary table is reprogrammed in-band with a drain handshake.

## Interface
- `data_width`, 8: key and boundary width in bits.
- `levels`, 3: tree depth = pipeline latency; table holds `2**levels - 1` boundaries; `range_id` is `levels` bits.
- `tag_width`, 8: side-band tag width (used only when `RANGE_MATCH_TAG_EN` is defined).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  key present.
- `in_ready`  out  1  pipeline accepts a key this cycle.
- `in_key`  in  `data_width`  key to classify.
- `in_tag`  in  `tag_width`  side-band tag (macro-gated).
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `range_id`  out  `levels`  number of boundaries less than or equal to the key.
- `out_tag`  out  `tag_width`  tag aligned with `range_id` (macro-gated).
- `cfg_we`  in  1  boundary write request; held until accepted.
- `cfg_addr`  in  `levels`  boundary index, 0 .. `2**levels - 2`.
- `cfg_data`  in  `data_width`  boundary value.
- `cfg_ready`  out  1  pipeline empty; a write with `cfg_we` high is performed this cycle.

## Operation
- Table entries b[0..M-1], M = `2**levels - 1`, must be written in ascending order. Unsorted contents still produce the deterministic result defined by the rule below, but that result has no range meaning.
- Stage k (k = 0 .. `levels-1`) holds the key and a k-bit prefix p.
  - It compares the key against b[n], with n = ((p<<1)|1) << (`levels-1-k`) - 1.
  - It appends bit 1 if key >= b[n] (GTET), otherwise bit 0 (LT).
  - Unsigned compare.
- The final prefix is `range_id`.
- Global stall: `stall = out_valid & ~out_ready`. While stalled, every stage register holds its value.
- `in_ready = ~stall & ~cfg_we`. A pending write blocks new keys so the pipeline can drain. Bubbles advance normally.
- `cfg_ready = ~cfg_we_blocked_keys_in_flight`, i.e. high only when no stage holds a valid key and `out_valid` is 0. A write occurs on any cycle where `cfg_we & cfg_ready` is true. Because keys are blocked during the write, no in-flight key ever sees a mixed table.
- Reset values:
  - All stage valids 0.
  - `out_valid` 0.
  - `range_id` 0.
  - `out_tag` 0.
  - Every boundary all-ones. With this table any key < max gives id 0, and key = max gives `2**levels - 1`.
- `cfg_addr` equal to M (out of range) is ignored, but the write is still acknowledged through `cfg_ready`.
- Asserting reset mid-stream discards all in-flight keys and restores the all-ones table.

## Timing
- Latency is exactly `levels` cycles from accepted input (`in_valid & in_ready`) to `out_valid`, absent stalls.
- Throughput is one key per cycle.
- `range_id` and `out_tag` are registered outputs and stay stable while `out_valid & ~out_ready`.
- `in_ready` is combinational from `out_valid`, `out_ready` and `cfg_we`.
- A boundary write is visible to a key accepted in the cycle after the write.

## Configuration
- `RANGE_MATCH_TAG_EN` defined: `in_tag` and `out_tag` exist, and the tag travels through the pipeline with identical latency and stall behaviour.
- Not defined: both ports are absent and no tag registers are built.

## Structure
- Package `range_match_pkg` holds:
  - the node-index function n(k, p, levels);
  - localparam M;
  - the stage-record struct type (valid, key, prefix, tag).
- Sub-module `range_match_stage`: one registered compare level, parametrised by stage index k.
- The top level generates `levels` instances plus the boundary register file and the handshake logic.

## Test plan
- Setup: `levels`=3, boundaries 10, 20, ..., 70 written to addresses 0..6. Keys 9, 10, 35, 70, 255 -> `range_id` 0, 1, 3, 7, 7, each 3 cycles after acceptance.
- After reset, with no writes: key 254 -> 0; key 255 -> 7.
- Back-to-back stream of 20 keys with `out_ready` held 1: `in_ready` stays 1 and results come out in order on consecutive cycles.
- `out_ready` low for 5 cycles mid-stream: `range_id` held, `in_ready` 0, no key lost or duplicated; stream resumes in order.
- `cfg_we` raised with 3 keys in flight: `in_ready` drops at once, the 3 results drain, then `cfg_ready`=1 and the write lands. The next key sees the new boundary, e.g. b[3]=36 makes key 37 -> 4.
- `reset_n` pulsed low mid-stream: `out_valid` goes 0 immediately, and the table reads all-ones (key 35 -> 0).
